// File: rtl/types_amba_pkg.sv
// Shared AMBA/APB types.
//   mapinfo_type : one slave window, base inclusive, end exclusive (64-bit fields,
//                  32-bit APB masters compare the low 32 bits only)
//   apb_in_type  : master -> slave APB request
//   apb_out_type : slave -> master APB response
package types_amba_pkg;

   typedef struct packed {
      logic [63:0] addr_start;
      logic [63:0] addr_end;
   } mapinfo_type;

   typedef struct packed {
      logic        pselx;
      logic        penable;
      logic [31:0] paddr;
      logic        pwrite;
      logic [31:0] pwdata;
      logic [3:0]  pstrb;
      logic [2:0]  pprot;
   } apb_in_type;

   typedef struct packed {
      logic        pready;
      logic [31:0] prdata;
      logic        pslverr;
   } apb_out_type;

endpackage

// File: rtl/types_bus_ctrl_pkg.sv
// Types and constants shared by the APB bus controllers.
//   bus_ctrl_state_type   : transaction FSM states
//   BUS_CTRL_ERRCNT_WIDTH : width of the saturating error counter
package types_bus_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } bus_ctrl_state_type;

   localparam int unsigned BUS_CTRL_ERRCNT_WIDTH = 16;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational priority address decoder.
//   addr : byte address to decode
//   en   : per-slave enable mask; a disabled slave never hits
//   sel  : one-hot select, lowest matching index wins
//   hit  : at least one enabled slave matched
module apb_addr_decoder
   import types_amba_pkg::*;
#(
   parameter int unsigned SLV_TOTAL = 6,
   parameter mapinfo_type SLV_MAP [0:SLV_TOTAL-1] = '{default: '0}
) (
   input  logic [31:0]          addr,
   input  logic [SLV_TOTAL-1:0] en,
   output logic [SLV_TOTAL-1:0] sel,
   output logic                 hit
);

   always_comb begin
      sel = '0;
      hit = 1'b0;
      for (int unsigned i = 0; i < SLV_TOTAL; i++) begin
         if (!hit && en[i] &&
             (addr >= SLV_MAP[i].addr_start[31:0]) &&
             (addr <  SLV_MAP[i].addr_end[31:0])) begin
            sel[i] = 1'b1;
            hit    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/apb_slv_bus_ctrl.sv
// APB master / interconnect: one outstanding request, decoded to one of SLV_TOTAL slaves.
//   i_clk, i_nrst          : clock, async active-low reset
//   i_req_*, o_req_ready   : request port (valid/ready), address, direction, data, strobes
//   i_slv_en               : runtime slave enable mask, sampled at decode only
//   o_resp_*, i_resp_ready : response port, held until consumed
//   o_apbo, i_apbi         : per-slave APB request / response
//   o_err_cnt              : saturating count of errored transactions
module apb_slv_bus_ctrl
   import types_amba_pkg::*;
   import types_bus_ctrl_pkg::*;
#(
   parameter int unsigned SLV_TOTAL      = 6,
   parameter mapinfo_type SLV_MAP [0:SLV_TOTAL-1] = '{default: '0},
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                             i_clk,
   input  logic                             i_nrst,
   input  logic                             i_req_valid,
   output logic                             o_req_ready,
   input  logic [31:0]                      i_req_addr,
   input  logic                             i_req_write,
   input  logic [31:0]                      i_req_wdata,
   input  logic [3:0]                       i_req_wstrb,
   input  logic [SLV_TOTAL-1:0]             i_slv_en,
   output logic                             o_resp_valid,
   input  logic                             i_resp_ready,
   output logic [31:0]                      o_resp_rdata,
   output logic                             o_resp_err,
   output apb_in_type                       o_apbo [0:SLV_TOTAL-1],
   input  apb_out_type                      i_apbi [0:SLV_TOTAL-1],
   output logic [BUS_CTRL_ERRCNT_WIDTH-1:0] o_err_cnt
);

   bus_ctrl_state_type state_q, state_d;
   logic                             rdy_q;
   logic [SLV_TOTAL-1:0]             sel_q, sel_d;
   logic [31:0]                      addr_q, addr_d;
   logic                             write_q, write_d;
   logic [31:0]                      wdata_q, wdata_d;
   logic [3:0]                       wstrb_q, wstrb_d;
   logic [15:0]                      tmo_q, tmo_d;
   logic [31:0]                      rdata_q, rdata_d;
   logic                             err_q, err_d;
   logic [BUS_CTRL_ERRCNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
   logic                             err_set;

   logic [SLV_TOTAL-1:0] dec_sel;
   logic                 dec_hit;
   logic                 slv_ready;
   logic [31:0]          slv_rdata;
   logic                 slv_err;

   apb_addr_decoder #(
      .SLV_TOTAL (SLV_TOTAL),
      .SLV_MAP   (SLV_MAP)
   ) u_dec (
      .addr (i_req_addr),
      .en   (i_slv_en),
      .sel  (dec_sel),
      .hit  (dec_hit)
   );

   // Only the latched selected slave may complete the transfer.
   always_comb begin
      slv_ready = 1'b0;
      slv_rdata = '0;
      slv_err   = 1'b0;
      for (int unsigned i = 0; i < SLV_TOTAL; i++) begin
         if (sel_q[i]) begin
            slv_ready = i_apbi[i].pready;
            slv_rdata = i_apbi[i].prdata;
            slv_err   = i_apbi[i].pslverr;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      addr_d    = addr_q;
      write_d   = write_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      tmo_d     = tmo_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      err_set   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (i_req_valid && rdy_q) begin
               addr_d  = i_req_addr;
               write_d = i_req_write;
               wdata_d = i_req_wdata;
               wstrb_d = i_req_write ? i_req_wstrb : 4'h0;
               tmo_d   = '0;
               if (dec_hit) begin
                  sel_d   = dec_sel;
                  state_d = SETUP;
               end else begin
                  sel_d   = '0;
                  rdata_d = '0;
                  err_d   = 1'b1;
                  err_set = 1'b1;
                  state_d = RESP;
               end
            end
         end
         SETUP: state_d = ACCESS;
         ACCESS: begin
            if (slv_ready) begin
               rdata_d = (!write_q && !slv_err) ? slv_rdata : 32'h0;
               err_d   = slv_err;
               err_set = slv_err;
               state_d = RESP;
            end else if (tmo_q == 16'(TIMEOUT_CYCLES - 1)) begin
               rdata_d = '0;
               err_d   = 1'b1;
               err_set = 1'b1;
               state_d = RESP;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         RESP: if (i_resp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_set && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state_q   <= IDLE;
         rdy_q     <= 1'b0;
         sel_q     <= '0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         tmo_q     <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         rdy_q     <= 1'b1;
         sel_q     <= sel_d;
         addr_q    <= addr_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         tmo_q     <= tmo_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   // APB controls come straight from state flops, so reset drops them asynchronously.
   always_comb begin
      for (int unsigned i = 0; i < SLV_TOTAL; i++) begin
         o_apbo[i].pselx   = sel_q[i] & ((state_q == SETUP) | (state_q == ACCESS));
         o_apbo[i].penable = sel_q[i] & (state_q == ACCESS);
         o_apbo[i].paddr   = addr_q;
         o_apbo[i].pwrite  = write_q;
         o_apbo[i].pwdata  = wdata_q;
         o_apbo[i].pstrb   = wstrb_q;
         o_apbo[i].pprot   = 3'b000;
      end
   end

   // rdy_q keeps ready low during reset and until the first clock after release.
   assign o_req_ready  = rdy_q & (state_q == IDLE);
   assign o_resp_valid = (state_q == RESP);
   assign o_resp_rdata = rdata_q;
   assign o_resp_err   = err_q;
   assign o_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_apb_slv_bus_ctrl.sv
`timescale 1ns/1ps
module tb_apb_slv_bus_ctrl;
   import types_amba_pkg::*;

   localparam int unsigned N   = 6;
   localparam int unsigned TMO = 8;
   localparam mapinfo_type MAP [0:N-1] = '{
      '{64'h0001_0000, 64'h0001_1000},   // uart
      '{64'h0001_2000, 64'h0001_3000},   // prci
      '{64'h0006_0000, 64'h0006_1000},   // gpio
      '{64'h0008_0000, 64'h000A_0000},   // spi flash
      '{64'h000C_0000, 64'h000D_0000},   // irq ctrl
      '{64'h000F_F000, 64'h0010_0000}    // pnp
   };

   logic        clk = 1'b0;
   logic        nrst;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic [N-1:0] slv_en;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic [15:0] err_cnt;
   apb_in_type  apbo [0:N-1];
   apb_out_type apbi [0:N-1];

   always #5 clk = ~clk;

   apb_slv_bus_ctrl #(
      .SLV_TOTAL      (N),
      .SLV_MAP        (MAP),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .i_clk        (clk),
      .i_nrst       (nrst),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_addr   (req_addr),
      .i_req_write  (req_write),
      .i_req_wdata  (req_wdata),
      .i_req_wstrb  (req_wstrb),
      .i_slv_en     (slv_en),
      .o_resp_valid (resp_valid),
      .i_resp_ready (resp_ready),
      .o_resp_rdata (resp_rdata),
      .o_resp_err   (resp_err),
      .o_apbo       (apbo),
      .i_apbi       (apbi),
      .o_err_cnt    (err_cnt)
   );

   // Slave models: a selected slave answers after cfg_wait ACCESS cycles with
   // cfg_rdata + index; unselected slaves drive junk with pready/pslverr high.
   int unsigned cfg_wait;
   bit          cfg_hang;
   bit          cfg_slverr;
   logic [31:0] cfg_rdata;
   int unsigned acc_cnt [0:N-1];

   always @(posedge clk or negedge nrst) begin
      for (int i = 0; i < N; i++) begin
         if (!nrst) acc_cnt[i] <= 0;
         else if (apbo[i].pselx && apbo[i].penable && !apbi[i].pready) acc_cnt[i] <= acc_cnt[i] + 1;
         else acc_cnt[i] <= 0;
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         if (apbo[i].pselx) begin
            apbi[i].pready  = apbo[i].penable && !cfg_hang && (acc_cnt[i] == cfg_wait);
            apbi[i].prdata  = cfg_rdata + 32'(i);
            apbi[i].pslverr = cfg_slverr && apbo[i].penable && !cfg_hang && (acc_cnt[i] == cfg_wait);
         end else begin
            apbi[i].pready  = 1'b1;
            apbi[i].prdata  = 32'hDEAD_0000 | 32'(i);
            apbi[i].pslverr = 1'b1;
         end
      end
   end

   int n_tests = 0;
   int n_fail  = 0;
   int err_model = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference decode: first enabled window containing the address, else -1.
   function automatic int ref_decode(input logic [31:0] a, input logic [N-1:0] en);
      for (int i = 0; i < N; i++)
         if (en[i] && ({32'h0, a} >= MAP[i].addr_start) && ({32'h0, a} < MAP[i].addr_end))
            return i;
      return -1;
   endfunction

   function automatic logic any_bus();
      logic r = 1'b0;
      for (int i = 0; i < N; i++) r = r | apbo[i].pselx | apbo[i].penable;
      return r;
   endfunction

   task automatic run_txn(input string tag, input logic [31:0] addr, input bit wr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          input logic [N-1:0] en, input int unsigned wt, input bit hang,
                          input bit serr, input logic [31:0] rbase, input int hold);
      int idx, exp_lat, cyc, psel_cyc, pen_cyc;
      bit timed_out, exp_err, stray, addr_bad;
      logic [31:0] exp_rdata;

      idx       = ref_decode(addr, en);
      timed_out = hang || (wt >= TMO);
      exp_err   = (idx < 0) || timed_out || serr;
      exp_lat   = (idx < 0) ? 1 : (timed_out ? 2 + TMO : 3 + int'(wt));
      exp_rdata = (exp_err || wr) ? 32'h0 : rbase + 32'(idx);
      if (exp_err && err_model < 16'hFFFF) err_model++;

      cfg_wait = wt; cfg_hang = hang; cfg_slverr = serr; cfg_rdata = rbase;
      @(negedge clk);
      check({tag, "/req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_addr = addr; req_write = wr;
      req_wdata = wdata; req_wstrb = wstrb; slv_en = en;
      @(posedge clk);                               // accept: cycle 0
      @(negedge clk);
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
      slv_en = N'($urandom);                        // must not affect the running transfer
      cyc = 1; psel_cyc = 0; pen_cyc = 0; stray = 0; addr_bad = 0;
      while (!resp_valid && cyc < 100) begin
         for (int i = 0; i < N; i++) begin
            if (i == idx) begin
               if (apbo[i].pselx)   psel_cyc++;
               if (apbo[i].penable) pen_cyc++;
            end else if (apbo[i].pselx || apbo[i].penable) stray = 1;
            if (apbo[i].paddr !== addr) addr_bad = 1;
         end
         if (cyc == 1 && idx >= 0) begin
            check({tag, "/setup_penable"}, 32'(apbo[idx].penable), 32'd0);
            check({tag, "/pwrite"}, 32'(apbo[idx].pwrite), 32'(wr));
            check({tag, "/pwdata"}, apbo[idx].pwdata, wdata);
            check({tag, "/pstrb"},  32'(apbo[idx].pstrb), wr ? 32'(wstrb) : 32'd0);
            check({tag, "/pprot"},  32'(apbo[idx].pprot), 32'd0);
            check({tag, "/paddr_all"}, 32'(addr_bad), 32'd0);
         end
         @(negedge clk);
         cyc++;
      end
      check({tag, "/latency"}, 32'(cyc), 32'(exp_lat));
      check({tag, "/err"}, 32'(resp_err), 32'(exp_err));
      check({tag, "/rdata"}, resp_rdata, exp_rdata);
      check({tag, "/psel_cycles"}, 32'(psel_cyc), (idx < 0) ? 32'd0 : 32'(exp_lat - 1));
      check({tag, "/penable_cycles"}, 32'(pen_cyc), (idx < 0) ? 32'd0 : 32'(exp_lat - 2));
      check({tag, "/stray_psel"}, 32'(stray), 32'd0);
      check({tag, "/resp_psel"}, 32'(any_bus()), 32'd0);
      check({tag, "/err_cnt"}, 32'(err_cnt), 32'(err_model));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check({tag, "/hold_valid"}, 32'(resp_valid), 32'd1);
         check({tag, "/hold_rdata"}, resp_rdata, exp_rdata);
         check({tag, "/hold_req_ready"}, 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      check({tag, "/done_valid"}, 32'(resp_valid), 32'd0);
      check({tag, "/done_req_ready"}, 32'(req_ready), 32'd1);
   endtask

   logic [31:0] unmapped [0:5] = '{32'h0, 32'h0001_1000, 32'h0002_0000, 32'h0010_0000,
                                   32'hFFFF_FFFC, 32'h0001_1FFF};

   initial begin
      nrst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
      req_wstrb = '0; slv_en = '1; resp_ready = 1'b0;
      cfg_wait = 0; cfg_hang = 0; cfg_slverr = 0; cfg_rdata = '0;
      #1 nrst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst/req_ready", 32'(req_ready), 32'd0);
      check("rst/resp_valid", 32'(resp_valid), 32'd0);
      check("rst/bus", 32'(any_bus()), 32'd0);
      check("rst/paddr", apbo[3].paddr, 32'd0);
      check("rst/err_cnt", 32'(err_cnt), 32'd0);
      nrst = 1'b1;
      @(negedge clk);
      check("rst/req_ready_after", 32'(req_ready), 32'd1);

      //            tag          addr          wr  wdata          strb  en      wt hang serr rbase         hold
      run_txn("prci_read",  32'h0001_2004, 0, 32'h1111_2222, 4'hF, 6'h3F, 0, 0, 0, 32'hCAFE_0000, 0);
      run_txn("gpio_write", 32'h0006_0010, 1, 32'h5A5A_5A5A, 4'hF, 6'h3F, 3, 0, 0, 32'h1234_0000, 0);
      run_txn("unmapped",   32'h0002_0000, 0, 32'h0,         4'h0, 6'h3F, 0, 0, 0, 32'h0,         0);
      run_txn("irq_dis",    32'h000C_0000, 0, 32'h0,         4'h0, 6'h2F, 0, 0, 0, 32'h7700_0000, 0);
      run_txn("irq_en",     32'h000C_0000, 0, 32'h0,         4'h0, 6'h3F, 1, 0, 0, 32'h7700_0000, 0);
      run_txn("pnp_tmo",    32'h000F_F000, 0, 32'h0,         4'h0, 6'h3F, 0, 1, 0, 32'h5500_0000, 0);
      run_txn("hold5",      32'h0008_0100, 0, 32'h0,         4'h3, 6'h3F, 2, 0, 0, 32'hBEEF_0000, 5);
      run_txn("wait_max",   32'h0001_0FFF, 0, 32'h0,         4'h0, 6'h3F, TMO-1, 0, 0, 32'hA000_0000, 0);
      run_txn("wait_over",  32'h0001_0000, 1, 32'h0F0F_0F0F, 4'h5, 6'h3F, TMO, 0, 0, 32'h0,       0);
      run_txn("slverr_rd",  32'h0006_0FFC, 0, 32'h0,         4'h0, 6'h3F, 1, 0, 1, 32'hC000_0000, 1);
      run_txn("end_excl",   32'h0001_1000, 0, 32'h0,         4'h0, 6'h3F, 0, 0, 0, 32'h0,         0);
      run_txn("pnp_last",   32'h000F_FFFF, 0, 32'h0,         4'h0, 6'h3F, 0, 0, 0, 32'h9900_0000, 0);

      for (int t = 0; t < 40; t++) begin
         int s;
         logic [31:0] a, size;
         logic [N-1:0] en;
         s = $urandom_range(0, N - 1);
         size = MAP[s].addr_end[31:0] - MAP[s].addr_start[31:0];
         case ($urandom_range(0, 3))
            0: a = MAP[s].addr_start[31:0] + ($urandom % size);
            1: a = MAP[s].addr_start[31:0];
            2: a = MAP[s].addr_end[31:0] - 32'd1;
            default: a = unmapped[$urandom_range(0, 5)];
         endcase
         en = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
         run_txn("rand", a, 1'($urandom), $urandom, 4'($urandom), en,
                 $urandom_range(0, TMO), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 5) == 0), $urandom, $urandom_range(0, 2));
      end

      // Reset during ACCESS: bus drops at once, transfer is dropped without a response.
      cfg_wait = 0; cfg_hang = 1; cfg_slverr = 0;
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h0006_0020; req_write = 1'b0; slv_en = '1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("rstmid/penable_before", 32'(apbo[2].penable), 32'd1);
      #2 nrst = 1'b0;
      #1;
      check("rstmid/bus", 32'(any_bus()), 32'd0);
      check("rstmid/req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      nrst = 1'b1;
      err_model = 0;
      @(negedge clk);
      check("rstmid/resp_valid", 32'(resp_valid), 32'd0);
      check("rstmid/err_cnt", 32'(err_cnt), 32'(err_model));
      check("rstmid/req_ready_after", 32'(req_ready), 32'd1);
      run_txn("post_rst", 32'h0001_2000, 0, 32'h0, 4'h0, 6'h3F, 0, 0, 0, 32'h4242_0000, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_slv_bus_ctrl.md
# apb_slv_bus_ctrl

Parametrised APB master/interconnect for peripheral buses. Accepts single read/write requests on a valid/ready port and decodes the address against a per-instance slave map. Runs the APB SETUP/ACCESS protocol on the selected slave and returns data and error status. Beyond static slave indexing, it also reports unmapped-address errors and slave timeouts, supports a runtime slave-enable mask, and keeps a saturating error counter.

## Interface
Parameters:
- SLV_TOTAL, 6: number of APB slaves; must be at least 1.
- SLV_MAP, none (required): `mapinfo_type [0:SLV_TOTAL-1]` holding base (inclusive) and end (exclusive) of each slave.
- TIMEOUT_CYCLES, 256: ACCESS cycles without `pready` before abort; range 2..65535.

Ports:
- `i_clk`  in  1  clock, rising edge.
- `i_nrst`  in  1  reset, asynchronous, active-low.
- `i_req_valid`  in  1  request valid.
- `o_req_ready`  out  1  request accepted when this and `i_req_valid` are both high.
- `i_req_addr`  in  32  byte address, compared against the low 32 bits of `SLV_MAP`.
- `i_req_write`  in  1  1 = write, 0 = read.
- `i_req_wdata`  in  32  write data.
- `i_req_wstrb`  in  4  byte strobes; forced to 0 on reads.
- `i_slv_en`  in  SLV_TOTAL  runtime enable; a disabled slave decodes as unmapped.
- `o_resp_valid`  out  1  response valid, held until `i_resp_ready`.
- `i_resp_ready`  in  1  response consumed.
- `o_resp_rdata`  out  32  read data; 0 for writes and errors.
- `o_resp_err`  out  1  error: unmapped address, timeout, or `pslverr`.
- `o_apbo`  out  SLV_TOTAL×`apb_in_type`  per-slave APB request.
- `i_apbi`  in  SLV_TOTAL×`apb_out_type`  per-slave APB response.
- `o_err_cnt`  out  16  saturating count of errored transactions.

## Operation
- States:
  - IDLE: `o_req_ready`=1. On accept, latch address, direction, data and strobes, and decode.
    - If one or more slaves hit (`base <= addr < end` and enabled), the lowest index wins; go to SETUP.
    - Otherwise go to RESP with err=1.
  - SETUP: `pselx`=1 and `penable`=0 on the selected slave only. Next state is ACCESS.
  - ACCESS: `pselx`=1, `penable`=1, and timeout counter `tmo` increments each cycle.
    - On `pready`: capture `prdata` (reads only) and `pslverr`, then go to RESP.
    - If `tmo`==TIMEOUT_CYCLES-1 and no `pready`: err=1, rdata=0, go to RESP.
  - RESP: `o_resp_valid`=1. When `i_resp_ready`=1, go to IDLE.
- `tmo` clears on entering SETUP.
- Non-selected slaves see `pselx`=0 and `penable`=0 at all times. `paddr`, `pwdata` and `pstrb` are driven from the latched values for every slave. `pprot` is 3'b000.
- `o_err_cnt` increments once per RESP entry with err=1 and saturates at 16'hFFFF.
- `i_slv_en` is sampled only at decode. Changes during a transaction have no effect on it.
- Response from a slave not currently selected: ignored.
- Reset values: state=IDLE; `o_req_ready`=1 after reset release and 0 while `i_nrst`=0. `o_resp_valid`=0, `o_resp_rdata`=0, `o_resp_err`=0, `o_err_cnt`=0, all `pselx`/`penable`=0, `paddr`/`pwdata`/`pstrb`=0.
- Reset asserted mid-transaction deasserts `psel`/`penable` asynchronously. The transaction is dropped with no response.

## Timing
- Accept at cycle 0 → SETUP cycle 1 → ACCESS cycle 2.
- With zero slave wait states, `o_resp_valid` rises at cycle 3 (minimum mapped latency 3 cycles).
- Each slave wait state adds 1 cycle.
- Unmapped or disabled address: `o_resp_valid` at cycle 1.
- Timeout: `o_resp_valid` at cycle 2+TIMEOUT_CYCLES.
- Back-to-back throughput: at most one transaction per 4 cycles. The next request can be accepted the cycle after the RESP handshake.
- All outputs are registered; no combinational path from `i_apbi` to the response outputs.

## Structure
- Shared package `types_bus_ctrl_pkg`:
  - state enum `bus_ctrl_state_type` (IDLE, SETUP, ACCESS, RESP);
  - `BUS_CTRL_ERRCNT_WIDTH` = 16.
- `mapinfo_type`, `apb_in_type` and `apb_out_type` come from `types_amba_pkg`.
- Sub-module `apb_addr_decoder`: combinational priority decode of address plus enable mask against `SLV_MAP`. Outputs a one-hot select and a hit flag. Reusable by other bus controllers.
- Top level holds the FSM, latches, timeout counter and error counter.

## Test plan
Instance: SLV_TOTAL=6 with the standard peripheral map (uart 0x10000–0x11000 … pnp 0xFF000–0x100000), TIMEOUT_CYCLES=8.
1. Read 0x12004 (PRCI, slave 1), slave returns `pready` immediately with `prdata`=0xCAFE0001 → only `pselx[1]` is asserted; SETUP at cycle 1, ACCESS at cycle 2; resp at cycle 3 with rdata=0xCAFE0001 and err=0.
2. Write 0x60010 (GPIO), data=0x5A5A5A5A, strb=4'hF, 3 slave wait states → `pwrite`=1, `pwdata` correct; resp at cycle 6 with rdata=0 and err=0.
3. Read 0x20000 (unmapped) → no `psel` asserted; resp at cycle 1 with err=1; `o_err_cnt`=1.
4. Read 0xC0000 with `i_slv_en[4]`=0 → treated as unmapped, err=1. Then set `i_slv_en[4]`=1 and repeat → normal access.
5. Read 0xFF000 with the slave never asserting `pready` → `penable` high for 8 cycles; resp at cycle 10 with err=1 and rdata=0; `psel` low on the response cycle.
6. Hold `i_resp_ready`=0 for 5 cycles → resp valid and data held, `o_req_ready`=0. Also assert `i_nrst` low during ACCESS → `psel`/`penable` drop the same cycle, and after release `o_resp_valid`=0 and `o_err_cnt`=0.
